// File: rtl/tff_pkg.sv
// Shared direction encodings and parameter legality limits for the T-flip-flop up/down counter.
package tff_pkg;

    localparam logic DIR_UP = 1'b1;
    localparam logic DIR_DN = 1'b0;

    localparam int WIDTH_MIN = 2;
    localparam int WIDTH_MAX = 16;
    localparam int MOD_MIN   = 2;

    // The modulus may not exceed the state space of the chosen width.
    function automatic bit params_legal(input int width, input int mod);
        if (width < WIDTH_MIN || width > WIDTH_MAX) return 1'b0;
        return (mod >= MOD_MIN) && (mod <= (1 << width));
    endfunction

endpackage

// File: rtl/tff_cell.sv
// One T flip-flop: toggles on the rising clk edge when t=1; async active-low reset clears it.
// Latency: 1 cycle t->q; qb is the combinational complement; no backpressure.
module tff_cell (
    input  logic clk,
    input  logic rst,
    input  logic t,
    output logic q,
    output logic qb
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q <= 1'b0;
        end else if (t) begin
            q <= ~q;
        end
    end

    assign qb = ~q;

endmodule

// File: rtl/tff_updn_counter.sv
// Modulo-MOD up/down counter with parallel load and clamp, built from T flip-flops; optional saturation.
// Latency: 1 cycle for load/count, tc combinational, wrap registered; no backpressure (en is a plain enable).
module tff_updn_counter
    import tff_pkg::*;
#(
    parameter int WIDTH    = 4,
    parameter int MOD      = 2 ** WIDTH,
    parameter bit SATURATE = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up_dn,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qb,
    output logic             tc,
    output logic             wrap
);

    if (!params_legal(WIDTH, MOD)) begin : g_bad_params
        $error("tff_updn_counter: illegal WIDTH=%0d / MOD=%0d", WIDTH, MOD);
    end

    localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(MOD - 1);

    logic [WIDTH-1:0] next_q;
    logic [WIDTH-1:0] t;
    logic             at_top;
    logic             at_bot;

    always_comb begin
        at_top = (q == MAX_Q);
        at_bot = (q == '0);
        tc     = en & ~load & ((up_dn == DIR_UP) ? at_top : at_bot);
    end

    // Next state follows load > en > hold; every change, including load and clamp, goes through the toggle vector.
    always_comb begin
        next_q = q;
        if (load) begin
            next_q = (din > MAX_Q) ? MAX_Q : din;
        end else if (en) begin
            if (tc) begin
                if (!SATURATE) begin
                    next_q = (up_dn == DIR_UP) ? '0 : MAX_Q;
                end
            end else begin
                next_q = (up_dn == DIR_UP) ? q + 1'b1 : q - 1'b1;
            end
        end
        t = next_q ^ q;
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        tff_cell u_cell (
            .clk (clk),
            .rst (rst),
            .t   (t[i]),
            .q   (q[i]),
            .qb  (qb[i])
        );
    end

    // tc already excludes load, so a load edge can never raise wrap.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wrap <= 1'b0;
        end else begin
            wrap <= tc;
        end
    end

endmodule

// File: tb/tb_tff_updn_counter.sv
// Directed bench: three counters (MOD=16 wrap, MOD=10 wrap, MOD=10 saturate) share one stimulus stream,
// each compared every cycle against a behavioural model plus hand-computed spot values.
module tb_tff_updn_counter;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       up_dn;
    logic       load;
    logic [3:0] din;

    logic [3:0] q16, qb16, q10, qb10, q10s, qb10s;
    logic       tc16, wrap16, tc10, wrap10, tc10s, wrap10s;

    int checks = 0;
    int errors = 0;

    int mq   [3];
    bit mw   [3];
    int mods [3] = '{16, 10, 10};
    bit sats [3] = '{1'b0, 1'b0, 1'b1};

    always #5 clk = ~clk;

    tff_updn_counter #(.WIDTH(4), .MOD(16), .SATURATE(1'b0)) u_d16 (
        .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .load(load), .din(din),
        .q(q16), .qb(qb16), .tc(tc16), .wrap(wrap16));

    tff_updn_counter #(.WIDTH(4), .MOD(10), .SATURATE(1'b0)) u_d10 (
        .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .load(load), .din(din),
        .q(q10), .qb(qb10), .tc(tc10), .wrap(wrap10));

    tff_updn_counter #(.WIDTH(4), .MOD(10), .SATURATE(1'b1)) u_d10s (
        .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .load(load), .din(din),
        .q(q10s), .qb(qb10s), .tc(tc10s), .wrap(wrap10s));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic get_obs(input int i, output logic [3:0] oq, output logic [3:0] oqb,
                           output logic otc, output logic ow);
        case (i)
            0:       begin oq = q16;  oqb = qb16;  otc = tc16;  ow = wrap16;  end
            1:       begin oq = q10;  oqb = qb10;  otc = tc10;  ow = wrap10;  end
            default: begin oq = q10s; oqb = qb10s; otc = tc10s; ow = wrap10s; end
        endcase
    endtask

    function automatic bit model_tc(input int i);
        if (!en || load) return 1'b0;
        return up_dn ? (mq[i] == mods[i] - 1) : (mq[i] == 0);
    endfunction

    function automatic int model_next(input int i);
        if (load) return (int'(din) >= mods[i]) ? mods[i] - 1 : int'(din);
        if (!en) return mq[i];
        if (up_dn) begin
            if (mq[i] == mods[i] - 1) return sats[i] ? mq[i] : 0;
            return mq[i] + 1;
        end
        if (mq[i] == 0) return sats[i] ? 0 : mods[i] - 1;
        return mq[i] - 1;
    endfunction

    task automatic check_state(input string ph);
        logic [3:0] oq, oqb, e;
        logic       otc, ow;
        for (int i = 0; i < 3; i++) begin
            get_obs(i, oq, oqb, otc, ow);
            e = mq[i][3:0];
            chk($sformatf("%s d%0d q", ph, i), {28'b0, oq}, {28'b0, e});
            chk($sformatf("%s d%0d qb", ph, i), {28'b0, oqb}, {28'b0, ~e});
            chk($sformatf("%s d%0d wrap", ph, i), {31'b0, ow}, {31'b0, mw[i]});
        end
    endtask

    // Drive one cycle of inputs, check tc before the edge, then state after it.
    task automatic step(input string ph, input bit l, input logic [3:0] d, input bit e, input bit u);
        int nq [3];
        bit nt [3];
        logic [3:0] oq, oqb;
        logic       otc, ow;
        load = l; din = d; en = e; up_dn = u;
        #2;
        for (int i = 0; i < 3; i++) begin
            get_obs(i, oq, oqb, otc, ow);
            chk($sformatf("%s d%0d tc", ph, i), {31'b0, otc}, {31'b0, model_tc(i)});
            nt[i] = rst ? model_tc(i) : 1'b0;
            nq[i] = rst ? model_next(i) : 0;
        end
        @(posedge clk);
        for (int i = 0; i < 3; i++) begin
            mq[i] = nq[i];
            mw[i] = nt[i];
        end
        #1;
        check_state(ph);
    endtask

    initial begin
        rst = 1'b0; en = 1'b0; up_dn = 1'b1; load = 1'b0; din = 4'd0;
        for (int i = 0; i < 3; i++) begin mq[i] = 0; mw[i] = 1'b0; end

        @(posedge clk);
        @(posedge clk);
        #1;
        check_state("reset");
        chk("reset qb16 ones", {28'b0, qb16}, 32'd15);
        rst = 1'b1;

        // Count to 7, then reset asynchronously mid-cycle.
        for (int k = 0; k < 7; k++) step("count_up", 1'b0, 4'd0, 1'b1, 1'b1);
        chk("pre_reset q16", {28'b0, q16}, 32'd7);
        rst = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin mq[i] = 0; mw[i] = 1'b0; end
        chk("async_reset q16", {28'b0, q16}, 32'd0);
        chk("async_reset qb16", {28'b0, qb16}, 32'd15);
        chk("async_reset wrap16", {31'b0, wrap16}, 32'd0);
        check_state("async_reset");
        step("reset_vs_load", 1'b1, 4'd5, 1'b1, 1'b1);
        rst = 1'b1;
        for (int k = 0; k < 3; k++) step("post_reset", 1'b0, 4'd0, 1'b1, 1'b1);
        chk("post_reset q16", {28'b0, q16}, 32'd3);

        // Up wrap at MOD=10 (and saturation in the SATURATE copy).
        step("load8", 1'b1, 4'd8, 1'b0, 1'b0);
        step("up_wrap1", 1'b0, 4'd0, 1'b1, 1'b1);
        chk("up_wrap q10=9", {28'b0, q10}, 32'd9);
        chk("up_wrap tc10 at 9", {31'b0, tc10}, 32'd1);
        step("up_wrap2", 1'b0, 4'd0, 1'b1, 1'b1);
        chk("up_wrap q10=0", {28'b0, q10}, 32'd0);
        chk("up_wrap wrap10 pulse", {31'b0, wrap10}, 32'd1);
        chk("up_sat q10s=9", {28'b0, q10s}, 32'd9);
        chk("up_wrap q16=10", {28'b0, q16}, 32'd10);
        step("up_wrap3", 1'b0, 4'd0, 1'b1, 1'b1);
        chk("up_wrap q10=1", {28'b0, q10}, 32'd1);
        chk("up_wrap wrap10 low", {31'b0, wrap10}, 32'd0);

        // Down saturate.
        step("load1", 1'b1, 4'd1, 1'b0, 1'b1);
        for (int k = 0; k < 3; k++) begin
            step("down_sat", 1'b0, 4'd0, 1'b1, 1'b0);
            chk("down_sat q10s=0", {28'b0, q10s}, 32'd0);
        end
        chk("down_sat wrap10s pulse", {31'b0, wrap10s}, 32'd1);
        chk("down_wrap q10=8", {28'b0, q10}, 32'd8);
        chk("down_wrap q16=14", {28'b0, q16}, 32'd14);

        // Load priority and clamp, including a load taken while at the terminal.
        step("load_clamp", 1'b1, 4'd13, 1'b1, 1'b1);
        chk("load_clamp q10=9", {28'b0, q10}, 32'd9);
        chk("load_clamp q16=13", {28'b0, q16}, 32'd13);
        step("load_at_top", 1'b1, 4'd9, 1'b1, 1'b1);
        chk("load_at_top wrap10", {31'b0, wrap10}, 32'd0);
        step("load4", 1'b1, 4'd4, 1'b1, 1'b1);
        chk("load4 q10", {28'b0, q10}, 32'd4);

        // Hold then direction changes.
        step("load5", 1'b1, 4'd5, 1'b0, 1'b0);
        for (int k = 0; k < 4; k++) step("hold", 1'b0, 4'd0, 1'b0, 1'b1);
        chk("hold q10", {28'b0, q10}, 32'd5);
        step("dir_u1", 1'b0, 4'd0, 1'b1, 1'b1);
        step("dir_u2", 1'b0, 4'd0, 1'b1, 1'b1);
        chk("dir q10=7", {28'b0, q10}, 32'd7);
        step("dir_d1", 1'b0, 4'd0, 1'b1, 1'b0);
        step("dir_d2", 1'b0, 4'd0, 1'b1, 1'b0);
        chk("dir q10=5", {28'b0, q10}, 32'd5);
        chk("dir qb10", {28'b0, qb10}, 32'd10);

        // Natural modulo-16 rollover in both directions.
        step("load15", 1'b1, 4'd15, 1'b0, 1'b1);
        step("roll_up", 1'b0, 4'd0, 1'b1, 1'b1);
        chk("roll_up q16=0", {28'b0, q16}, 32'd0);
        chk("roll_up wrap16", {31'b0, wrap16}, 32'd1);
        step("roll_dn", 1'b0, 4'd0, 1'b1, 1'b0);
        chk("roll_dn q16=15", {28'b0, q16}, 32'd15);
        step("idle", 1'b0, 4'd0, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/tff_updn_counter.md
TFF_UPDN_COUNTER -- requirements
Module: tff_updn_counter

Interface
REQ-001 SHALL have parameter WIDTH, default 4: counter width in bits, legal range 2..16.
REQ-002 SHALL have parameter MOD, default 2**WIDTH: count modulus; state range is 0..MOD-1; legal range 2..2**WIDTH.
REQ-003 SHALL have parameter SATURATE, default 0: 0 = wrap at terminal; 1 = hold at terminal.
REQ-004 SHALL have port clk, input, 1 bit: single clock, all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port en, input, 1 bit: count enable.
REQ-007 SHALL have port up_dn, input, 1 bit: direction, 1 = up, 0 = down.
REQ-008 SHALL have port load, input, 1 bit: synchronous parallel load strobe.
REQ-009 SHALL have port din, input, WIDTH bits: parallel load value.
REQ-010 SHALL have port q, output, WIDTH bits: registered count.
REQ-011 SHALL have port qb, output, WIDTH bits: bitwise complement of q.
REQ-012 SHALL have port tc, output, 1 bit: combinational terminal-count flag.
REQ-013 SHALL have port wrap, output, 1 bit: registered one-cycle pulse on wrap or saturation.

Function
REQ-014 SHALL apply priority load > en > hold at each rising clk edge while rst=1.
REQ-015 SHALL, on load=1, set q to din on that edge (1-cycle latency), irrespective of en and up_dn.
REQ-016 SHALL, on load=1 with din >= MOD, set q to MOD-1 (clamp).
REQ-017 SHALL, on en=1 with load=0 and up_dn=1, set q to q+1 on that edge.
REQ-018 SHALL, on en=1 with load=0 and up_dn=0, set q to q-1 on that edge.
REQ-019 SHALL, on en=0 with load=0, hold q.
REQ-020 SHALL, with SATURATE=0, step up from MOD-1 to 0 and down from 0 to MOD-1.
REQ-021 SHALL, with SATURATE=1, hold MOD-1 when counting up and hold 0 when counting down.
REQ-022 SHALL drive tc=1 exactly when en=1, load=0, and either (up_dn=1, q=MOD-1) or (up_dn=0, q=0); tc=0 otherwise.
REQ-023 SHALL assert wrap for exactly the one cycle following any edge at which tc was 1, in both SATURATE modes.
REQ-024 SHALL keep wrap=0 after any edge at which load=1.
REQ-025 SHALL keep qb equal to ~q at all times, including during reset.
REQ-026 SHALL evaluate a change of up_dn mid-count with the same 1-cycle latency; there is no pipeline to flush.
REQ-027 SHALL, with MOD=2**WIDTH, make wrap-around equal natural modulo-2**WIDTH rollover.

Reset
REQ-028 SHALL, on rst=0, immediately set q=0, qb=all ones and wrap=0, without waiting for a clk edge.
REQ-029 SHALL, when rst=0 arrives mid-count or coincides with load, let reset win; the count restarts from 0 after release.
REQ-030 SHALL, at the first rising clk edge after rst returns to 1, apply normal load/en behaviour.

Structure
REQ-031 SHALL build each state bit from an instance of sub-module tff_cell: one T flip-flop with ports t, clk, rst (async active-low), q, qb; toggles when t=1.
REQ-032 SHALL form the toggle vector combinationally as t[i] = next_q[i] XOR q[i], where next_q is selected by the priority rules above; load and clamp both use the toggle path.
REQ-033 SHALL place direction encodings (UP=1, DN=0) and the WIDTH/MOD legality limits in shared package tff_pkg.
REQ-034 SHALL flag an illegal WIDTH/MOD parameter combination at elaboration.
REQ-035 SHALL contain no latches and no gated clocks.

Verification
REQ-036 SHALL cover reset: WIDTH=4, MOD=16, assert rst=0 mid-count at q=7 -> q=0, qb=15, wrap=0 before the next edge; after release, 3 enabled up edges -> q=3.
REQ-037 SHALL cover up wrap: MOD=10, SATURATE=0, load 8, then en=1, up_dn=1 for 3 edges -> q=9,0,1; tc=1 while q=9; wrap=1 only in the cycle q=0.
REQ-038 SHALL cover down saturate: MOD=10, SATURATE=1, load 1, then en=1, up_dn=0 for 3 edges -> q=0,0,0; wrap pulses after each edge taken at q=0.
REQ-039 SHALL cover load priority and clamp: MOD=10, en=1, up_dn=1, load=1, din=13 -> q=9 next edge, wrap=0; load=1, din=4 -> q=4.
REQ-040 SHALL cover hold and direction change: q=5, en=0 for 4 edges -> q=5; then en=1 with up_dn=1,1,0,0 -> q=6,7,6,5; qb=~q checked on every cycle.
REQ-041 SHALL run every scenario for (WIDTH=4, MOD=16) and (WIDTH=4, MOD=10), checking q, qb, tc and wrap each cycle against a reference model.
